// File: rtl/sa_operand_feeder_pkg.sv
// Shared definitions for the systolic-array operand feeder.
//   - Default DATA_WIDTH / SIZE values.
//   - Feeder FSM state encoding.
//   - PE index helper that maps PE(i,j) (1-based) to its finish bit.
package sa_operand_feeder_pkg;

    localparam int unsigned DefDataWidth = 16;
    localparam int unsigned DefSize      = 32;

    typedef enum logic [1:0] {
        StIdle,
        StStream,
        StFlush,
        StDrain
    } state_e;

    // Bit position of PE(i,j) in the finish vector, i and j counted from 1.
    function automatic int unsigned pe_bit(input int unsigned i, input int unsigned j,
                                           input int unsigned size);
        return (i - 1) * size + (j - 1);
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage register chain used for operand skew and the marker/dump wavefront.
// Ports:
//   clk, rst  : clock and synchronous active-high reset (clears every stage)
//   data_i    : chain input
//   data_o    : chain output, data_i delayed by DEPTH cycles (a plain wire for DEPTH=0)
//   taps_o    : every tap; tap t (delay t) sits at [t*WIDTH +: WIDTH], tap 0 = data_i
module sa_skew_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           data_i,
    output logic [WIDTH-1:0]           data_o,
    output logic [(DEPTH+1)*WIDTH-1:0] taps_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_ctl;
        assign unused_ctl = clk ^ rst;
        assign taps_o     = data_i;
    end else begin : g_regs
        logic [DEPTH*WIDTH-1:0] stage_q, stage_d;

        always_comb begin
            stage_d = '0;
            stage_d[WIDTH-1:0] = data_i;
            for (int k = 1; k < int'(DEPTH); k++) begin
                stage_d[k*WIDTH +: WIDTH] = stage_q[(k-1)*WIDTH +: WIDTH];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                stage_q <= '0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign taps_o = {stage_q, data_i};
    end

    assign data_o = taps_o[DEPTH*WIDTH +: WIDTH];

endmodule

// File: rtl/sa_operand_feeder.sv
// Transmit side of the systolic-array operand interface.
// Accepts one A-column / B-row beat per cycle, drives in_left / in_up with diagonal skew,
// and generates the per-PE finish wavefront that restarts accumulation and dumps the
// previous tile. tile_done pulses when PE(1,1) latches the dumped tile.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   s_valid/s_ready   : operand beat handshake
//   s_a, s_b, s_last  : A column / B row lanes, last-k-of-tile flag
//   in_left, in_up    : skewed operands to the array
//   finish            : per-PE finish, bit (i-1)*SIZE+j-1 drives PE(i,j)
//   tile_done         : one-cycle pulse, dumped results complete
//   busy              : FSM not idle
module sa_operand_feeder
    import sa_operand_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned SIZE       = DefSize
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [SIZE*DATA_WIDTH-1:0] s_a,
    input  logic [SIZE*DATA_WIDTH-1:0] s_b,
    input  logic                       s_last,
    output logic [SIZE*DATA_WIDTH-1:0] in_left,
    output logic [SIZE*DATA_WIDTH-1:0] in_up,
    output logic [SIZE*SIZE-1:0]       finish,
    output logic                       tile_done,
    output logic                       busy
);

    localparam int unsigned LaneW      = SIZE * DATA_WIDTH;
    localparam int unsigned ChainDepth = 2 * SIZE - 2;
    localparam int unsigned CntW       = $clog2(2 * SIZE);
    localparam logic [CntW-1:0] DrainLast = CntW'(2 * SIZE - 2);

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [LaneW-1:0]  a_q, a_d, b_q, b_d;
    // md bit 0 = marker (first beat of a tile), bit 1 = dump (marker ends a previous tile)
    logic [1:0]        md_q, md_d;
    logic              tile_done_q, tile_done_d;
    logic              accept;
    logic [2*(ChainDepth+1)-1:0] md_taps;
    logic [1:0]        unused_md_end;
    logic              unused_dump;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        md_d    = 2'b00;
        s_ready = (state_q != StDrain);
        accept  = s_valid & s_ready;
        // Non-accepted cycles issue zero bubbles so the array never stalls.
        a_d     = accept ? s_a : '0;
        b_d     = accept ? s_b : '0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    md_d    = 2'b01;
                    state_d = s_last ? StFlush : StStream;
                end
            end
            StStream: begin
                if (accept && s_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                md_d = 2'b11;
                if (accept) begin
                    state_d = s_last ? StFlush : StStream;
                end else begin
                    state_d = StDrain;
                    cnt_d   = '0;
                end
            end
            StDrain: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == DrainLast) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            end
            default: state_d = StIdle;
        endcase

        // Registering the dump bit one tap early lines the pulse up with the cycle
        // PE(1,1) sees its finish for the dumping wave.
        tile_done_d = md_taps[2*(ChainDepth-1)+1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            md_q        <= '0;
            tile_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            md_q        <= md_d;
            tile_done_q <= tile_done_d;
        end
    end

    for (genvar i = 1; i <= SIZE; i++) begin : g_left
        logic [(SIZE-i+1)*DATA_WIDTH-1:0] unused_taps;
        sa_skew_line #(
            .WIDTH(DATA_WIDTH),
            .DEPTH(SIZE - i)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .data_i(a_q[i*DATA_WIDTH-1 -: DATA_WIDTH]),
            .data_o(in_left[i*DATA_WIDTH-1 -: DATA_WIDTH]),
            .taps_o(unused_taps)
        );
    end

    for (genvar j = 1; j <= SIZE; j++) begin : g_up
        logic [(SIZE-j+1)*DATA_WIDTH-1:0] unused_taps;
        sa_skew_line #(
            .WIDTH(DATA_WIDTH),
            .DEPTH(SIZE - j)
        ) u_line (
            .clk   (clk),
            .rst   (rst),
            .data_i(b_q[j*DATA_WIDTH-1 -: DATA_WIDTH]),
            .data_o(in_up[j*DATA_WIDTH-1 -: DATA_WIDTH]),
            .taps_o(unused_taps)
        );
    end

    sa_skew_line #(
        .WIDTH(2),
        .DEPTH(ChainDepth)
    ) u_marker (
        .clk   (clk),
        .rst   (rst),
        .data_i(md_q),
        .data_o(unused_md_end),
        .taps_o(md_taps)
    );

    // PE(i,j) sees a beat 2*SIZE-i-j cycles after PE(SIZE,SIZE), so it takes that tap.
    for (genvar i = 1; i <= SIZE; i++) begin : g_fin_row
        for (genvar j = 1; j <= SIZE; j++) begin : g_fin_col
            assign finish[pe_bit(i, j, SIZE)] = md_taps[2*(2*SIZE-i-j)];
        end
    end

    assign unused_dump = ^md_taps;
    assign tile_done   = tile_done_q;
    assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_sa_operand_feeder.sv
module tb_sa_operand_feeder;
    localparam int DW   = 16;
    localparam int S    = 4;
    localparam int LW   = S * DW;
    localparam int KMAX = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [LW-1:0] s_a;
    logic [LW-1:0] s_b;
    logic          s_last;
    logic [LW-1:0] in_left;
    logic [LW-1:0] in_up;
    logic [S*S-1:0] finish;
    logic          tile_done;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int am[S][KMAX];
    int bm[KMAX][S];
    int exp_cyc_q[$];
    int exp_res_q[$];

    // Behavioural PE array: operands enter at column/row SIZE and hop toward 1.
    int pa[S][S];
    int pb[S][S];
    int acc[S][S];
    int res[S][S];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_operand_feeder #(
        .DATA_WIDTH(DW),
        .SIZE      (S)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_last   (s_last),
        .in_left  (in_left),
        .in_up    (in_up),
        .finish   (finish),
        .tile_done(tile_done),
        .busy     (busy)
    );

    always @(posedge clk) begin
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < S; j++) begin
                int a_in, b_in, p;
                a_in = (j == S - 1) ? int'($signed(in_left[i*DW +: DW])) : pa[i][j+1];
                b_in = (i == S - 1) ? int'($signed(in_up[j*DW +: DW])) : pb[i+1][j];
                p = (a_in * b_in) >>> 8;
                pa[i][j] <= a_in;
                pb[i][j] <= b_in;
                if (finish[i*S+j]) begin
                    res[i][j] <= acc[i][j];
                    acc[i][j] <= p;
                end else begin
                    acc[i][j] <= acc[i][j] + p;
                end
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mats();
        for (int i = 0; i < S; i++) for (int k = 0; k < KMAX; k++) am[i][k] = 0;
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < S; j++) bm[k][j] = 0;
    endtask

    task automatic beat(input int k, input logic last);
        s_valid = 1'b1;
        s_last  = last;
        for (int l = 0; l < S; l++) begin
            s_a[l*DW +: DW] = 16'(am[l][k]);
            s_b[l*DW +: DW] = 16'(bm[k][l]);
        end
        chk("beat_ready", longint'(s_ready), 1);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;
    endtask

    task automatic send_tile(input int k_n, input bit gaps);
        for (int k = 0; k < k_n; k++) begin
            if (gaps && k > 0) step(1);
            beat(k, k == k_n - 1);
        end
    endtask

    task automatic push_expect(input int k_n, input int done_cyc);
        exp_cyc_q.push_back(done_cyc);
        for (int i = 0; i < S; i++) begin
            for (int j = 0; j < S; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < k_n; k++) s += (am[i][k] * bm[k][j]) >>> 8;
                exp_res_q.push_back(s);
            end
        end
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 64) begin
            step(1);
            n++;
        end
        chk(name, longint'(busy), 0);
        step(4);
    endtask

    // Monitor: on every tile_done pulse, check its cycle and, once PE(1,1) has latched,
    // the whole result matrix.
    initial begin
        int ecyc, got_cyc, e;
        forever begin
            @(negedge clk);
            if (tile_done === 1'b1) begin
                got_cyc = cyc;
                if (exp_cyc_q.size() == 0) begin
                    chk("tile_done_spurious", longint'(tile_done), 0);
                end else begin
                    ecyc = exp_cyc_q.pop_front();
                    chk("tile_done_cycle", got_cyc, ecyc);
                    @(posedge clk);
                    #1;
                    for (int i = 0; i < S; i++) begin
                        for (int j = 0; j < S; j++) begin
                            e = exp_res_q.pop_front();
                            chk($sformatf("result_%0d_%0d", i + 1, j + 1), res[i][j], e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_a     = '0;
        s_b     = '0;

        // 1: reset state
        step(3);
        rst = 1'b0;
        chk("rst_in_left", in_left, 0);
        chk("rst_in_up", in_up, 0);
        chk("rst_finish", finish, 0);
        chk("rst_s_ready", longint'(s_ready), 1);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_tile_done", longint'(tile_done), 0);
        step(5);

        // 2: single-beat tile, skew and finish timing
        clear_mats();
        for (int l = 0; l < S; l++) begin
            am[l][0] = 256;
            bm[0][l] = 256;
        end
        c0 = cyc;
        push_expect(1, c0 + 8);
        beat(0, 1'b1);
        chk("t2_left4_c1", in_left[63:48], 16'h0100);
        chk("t2_left1_c1", in_left[15:0], 0);
        chk("t2_up4_c1", in_up[63:48], 16'h0100);
        chk("t2_finish_c1", finish, 16'h8000);
        chk("t2_ready_flush", longint'(s_ready), 1);
        chk("t2_busy_flush", longint'(busy), 1);
        step(1);
        chk("t2_ready_drain", longint'(s_ready), 0);
        step(2);
        chk("t2_left1_c4", in_left[15:0], 16'h0100);
        chk("t2_up1_c4", in_up[15:0], 16'h0100);
        chk("t2_left4_c4", in_left[63:48], 0);
        step(3);
        chk("t2_finish11_c7", longint'(finish[0]), 1);
        step(1);
        chk("t2_busy_c8", longint'(busy), 1);
        step(1);
        chk("t2_busy_c9", longint'(busy), 0);
        step(4);

        // 3: identity GEMM, result equals B
        clear_mats();
        for (int i = 0; i < S; i++) am[i][i] = 256;
        for (int k = 0; k < S; k++) for (int j = 0; j < S; j++) bm[k][j] = (k * S + j + 1) * 256;
        c0 = cyc;
        push_expect(4, c0 + 11);
        send_tile(4, 1'b0);
        step(7);
        chk("t3_busy_last_drain", longint'(busy), 1);
        step(1);
        chk("t3_busy_fall", longint'(busy), 0);
        step(4);

        // 4: same tile with a bubble between every beat
        c0 = cyc;
        push_expect(4, c0 + 14);
        send_tile(4, 1'b1);
        wait_idle("t4_drain_bound");

        // 5: back-to-back K=8 tiles, s_valid held high
        clear_mats();
        for (int i = 0; i < S; i++) begin
            for (int k = 0; k < KMAX; k++) am[i][k] = ((i + k) % 2 == 0) ? 256 : -256;
        end
        for (int k = 0; k < KMAX; k++) for (int j = 0; j < S; j++) bm[k][j] = (j - k) * 128;
        c0 = cyc;
        push_expect(8, c0 + 15);
        send_tile(8, 1'b0);
        for (int i = 0; i < S; i++) for (int k = 0; k < KMAX; k++) am[i][k] = ((i + k) % 3) * 256;
        for (int k = 0; k < KMAX; k++) begin
            for (int j = 0; j < S; j++) bm[k][j] = ((k + 2 * j) % 5 - 2) * 256;
        end
        push_expect(8, c0 + 23);
        send_tile(8, 1'b0);
        wait_idle("t5_drain_bound");

        // 6: reset after 2 of 4 beats, then a fresh tile
        clear_mats();
        for (int i = 0; i < S; i++) am[i][i] = 512;
        for (int k = 0; k < S; k++) for (int j = 0; j < S; j++) bm[k][j] = (j * 4 - k) * 256;
        beat(0, 1'b0);
        beat(1, 1'b0);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        chk("t6_in_left", in_left, 0);
        chk("t6_in_up", in_up, 0);
        chk("t6_finish", finish, 0);
        chk("t6_busy", longint'(busy), 0);
        chk("t6_s_ready", longint'(s_ready), 1);
        step(20);
        c0 = cyc;
        push_expect(4, c0 + 11);
        send_tile(4, 1'b0);
        wait_idle("t6_drain_bound");

        chk("scoreboard_empty", exp_cyc_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
